// File: rtl/alu_op_sequencer.sv
// Operation sequencer for the 8-bit calculator datapath: owns the A/B/Y registers,
// drives the ALU opcode select, and queues one extra request behind the running op.
module alu_op_sequencer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             go,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] sw_val,
    input  logic [WIDTH-1:0] alu_y,
    output logic [3:0]       alu_sel,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Y,
    output logic             busy,
    output logic             done,
    output logic             zero,
    output logic             ovf_err,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StExec,
        StSwp2,
        StSwp3,
        StDone
    } state_e;

    localparam logic [3:0] OpLastAlu = 4'd12;
    localparam logic [3:0] OpSto     = 4'd13;
    localparam logic [3:0] OpSwp     = 4'd14;
    localparam logic [3:0] OpLoad    = 4'd15;

    state_e           stateQ, stateD;
    logic             goQ;
    logic [3:0]       opQ, opD;
    logic [3:0]       selQ, selD;
    logic [WIDTH-1:0] aQ, aD, bQ, bD, yQ, yD, tmpQ, tmpD;
    logic             busyQ, busyD;
    logic             zeroQ, zeroD;
    logic             ovfQ, ovfD;
    logic             pendingQ, pendingD;
    logic [3:0]       pendOpQ, pendOpD;
    logic [CNT_W-1:0] cntQ, cntD;
    logic             goRise;

    assign goRise = go & ~goQ;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stateQ   <= StIdle;
            goQ      <= 1'b0;
            opQ      <= '0;
            selQ     <= '0;
            aQ       <= '0;
            bQ       <= '0;
            yQ       <= '0;
            tmpQ     <= '0;
            busyQ    <= 1'b0;
            zeroQ    <= 1'b1;
            ovfQ     <= 1'b0;
            pendingQ <= 1'b0;
            pendOpQ  <= '0;
            cntQ     <= '0;
        end else begin
            stateQ   <= stateD;
            goQ      <= go;
            opQ      <= opD;
            selQ     <= selD;
            aQ       <= aD;
            bQ       <= bD;
            yQ       <= yD;
            tmpQ     <= tmpD;
            busyQ    <= busyD;
            zeroQ    <= zeroD;
            ovfQ     <= ovfD;
            pendingQ <= pendingD;
            pendOpQ  <= pendOpD;
            cntQ     <= cntD;
        end
    end

    always_comb begin
        stateD   = stateQ;
        opD      = opQ;
        selD     = selQ;
        aD       = aQ;
        bD       = bQ;
        yD       = yQ;
        tmpD     = tmpQ;
        busyD    = busyQ;
        zeroD    = zeroQ;
        ovfD     = ovfQ;
        pendingD = pendingQ;
        pendOpD  = pendOpQ;
        cntD     = cntQ;

        unique case (stateQ)
            StIdle: begin
                // A request captured during the final DONE cycle starts from here.
                if (pendingQ) begin
                    opD      = pendOpQ;
                    selD     = pendOpQ;
                    busyD    = 1'b1;
                    pendingD = 1'b0;
                    stateD   = StSettle;
                    if (goRise) begin
                        pendingD = 1'b1;
                        pendOpD  = op;
                    end
                end else if (goRise) begin
                    opD    = op;
                    selD   = op;
                    busyD  = 1'b1;
                    stateD = StSettle;
                end
            end
            StSettle: stateD = StExec;
            StExec: begin
                stateD = StDone;
                if (opQ <= OpLastAlu) begin
                    yD    = alu_y;
                    zeroD = (alu_y == '0);
                end else if (opQ == OpSto) begin
                    aD = yQ;
                end else if (opQ == OpLoad) begin
                    aD = sw_val;
                end else if (opQ == OpSwp) begin
                    tmpD   = aQ;
                    stateD = StSwp2;
                end
            end
            StSwp2: begin
                aD     = bQ;
                stateD = StSwp3;
            end
            StSwp3: begin
                bD     = tmpQ;
                stateD = StDone;
            end
            StDone: begin
                cntD = cntQ + 1'b1;
                if (pendingQ) begin
                    opD      = pendOpQ;
                    selD     = pendOpQ;
                    pendingD = 1'b0;
                    stateD   = StSettle;
                end else begin
                    busyD  = 1'b0;
                    stateD = StIdle;
                end
            end
            default: stateD = StIdle;
        endcase

        // Requests arriving mid-operation: queue one, drop and flag anything beyond.
        if (goRise && stateQ != StIdle) begin
            if (!pendingQ) begin
                pendingD = 1'b1;
                pendOpD  = op;
            end else begin
                ovfD = 1'b1;
            end
        end
    end

    assign alu_sel  = selQ;
    assign A        = aQ;
    assign B        = bQ;
    assign Y        = yQ;
    assign busy     = busyQ;
    assign done     = (stateQ == StDone);
    assign zero     = zeroQ;
    assign ovf_err  = ovfQ;
    assign op_count = cntQ;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: vector table, hand-written overlap/reset
// sequences, and randomized ops against an operation-level reference model.
module tb_alu_op_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       go;
    logic [3:0] op;
    logic [7:0] swVal;
    logic [7:0] aluY;
    logic [3:0] aluSel;
    logic [7:0] dutA, dutB, dutY;
    logic       busy, done, zero, ovfErr;
    logic [7:0] opCount;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] mA, mB, mY, mCnt;
    logic       mZero;

    always #5 clock = ~clock;

    alu_op_sequencer #(.WIDTH(8), .CNT_W(8)) dut (
        .clock    (clock),
        .reset    (reset),
        .go       (go),
        .op       (op),
        .sw_val   (swVal),
        .alu_y    (aluY),
        .alu_sel  (aluSel),
        .A        (dutA),
        .B        (dutB),
        .Y        (dutY),
        .busy     (busy),
        .done     (done),
        .zero     (zero),
        .ovf_err  (ovfErr),
        .op_count (opCount)
    );

    // Behavioural ALU bank the sequencer drives.
    function automatic logic [7:0] aluF(input logic [3:0] s, input logic [7:0] a,
                                        input logic [7:0] b);
        case (s)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return {7'd0, a < b};
            4'd3:    return a << 1;
            4'd4:    return a >> 1;
            4'd5:    return a & b;
            4'd6:    return a | b;
            4'd7:    return a ^ b;
            4'd8:    return ~(a & b);
            4'd9:    return ~(a | b);
            4'd10:   return ~(a ^ b);
            4'd11:   return ~a;
            4'd12:   return -a;
            default: return 8'h00;
        endcase
    endfunction

    assign aluY = aluF(aluSel, dutA, dutB);

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic modelReset();
        mA = 8'h00; mB = 8'h00; mY = 8'h00; mZero = 1'b1; mCnt = 8'h00;
    endtask

    task automatic modelApply(input logic [3:0] o, input logic [7:0] s);
        logic [7:0] t;
        if (o <= 4'd12) begin
            mY    = aluF(o, mA, mB);
            mZero = (mY == 8'h00);
        end else if (o == 4'd13) begin
            mA = mY;
        end else if (o == 4'd15) begin
            mA = s;
        end else begin
            t  = mA;
            mA = mB;
            mB = t;
        end
        mCnt = mCnt + 8'd1;
    endtask

    task automatic checkModel(input string tag);
        check({tag, ".A"}, dutA, mA);
        check({tag, ".B"}, dutB, mB);
        check({tag, ".Y"}, dutY, mY);
        check({tag, ".zero"}, zero, mZero);
        check({tag, ".count"}, opCount, mCnt);
    endtask

    // Issue one go pulse and return negedges until done is seen (3 for ALU, 5 for SWP).
    task automatic doOp(input logic [3:0] o, input logic [7:0] s, output int lat);
        @(negedge clock);
        op = o; swVal = s; go = 1'b1;
        @(negedge clock);
        go = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        @(negedge clock);
    endtask

    typedef struct {
        logic [3:0] op;
        logic [7:0] sw;
        logic [7:0] expA;
        logic [7:0] expB;
        logic [7:0] expY;
        logic       expZero;
        logic [7:0] expCnt;
        int         expLat;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int lat;
        int dones;
        int busyDrops;
        logic seenFirst;
        logic [3:0] rop;
        logic [7:0] rsw;

        vecs[0] = '{4'd15, 8'h2A, 8'h2A, 8'h00, 8'h00, 1'b1, 8'd1, 3};
        vecs[1] = '{4'd15, 8'h05, 8'h05, 8'h00, 8'h00, 1'b1, 8'd2, 3};
        vecs[2] = '{4'd14, 8'h00, 8'h00, 8'h05, 8'h00, 1'b1, 8'd3, 5};
        vecs[3] = '{4'd15, 8'h03, 8'h03, 8'h05, 8'h00, 1'b1, 8'd4, 3};
        vecs[4] = '{4'd0,  8'h00, 8'h03, 8'h05, 8'h08, 1'b0, 8'd5, 3};
        vecs[5] = '{4'd15, 8'h07, 8'h07, 8'h05, 8'h08, 1'b0, 8'd6, 3};
        vecs[6] = '{4'd14, 8'h00, 8'h05, 8'h07, 8'h08, 1'b0, 8'd7, 5};
        vecs[7] = '{4'd15, 8'h07, 8'h07, 8'h07, 8'h08, 1'b0, 8'd8, 3};
        vecs[8] = '{4'd1,  8'h00, 8'h07, 8'h07, 8'h00, 1'b1, 8'd9, 3};
        vecs[9] = '{4'd13, 8'h00, 8'h00, 8'h07, 8'h00, 1'b1, 8'd10, 3};

        reset = 1'b0; go = 1'b0; op = 4'd0; swVal = 8'h00;
        modelReset();
        repeat (3) @(negedge clock);
        check("rst.A", dutA, 8'h00);
        check("rst.B", dutB, 8'h00);
        check("rst.Y", dutY, 8'h00);
        check("rst.alu_sel", aluSel, 4'd0);
        check("rst.busy", busy, 1'b0);
        check("rst.done", done, 1'b0);
        check("rst.zero", zero, 1'b1);
        check("rst.ovf", ovfErr, 1'b0);
        check("rst.count", opCount, 8'd0);
        reset = 1'b1;
        @(negedge clock);

        // Directed vector table
        foreach (vecs[i]) begin
            doOp(vecs[i].op, vecs[i].sw, lat);
            check($sformatf("vec%0d.lat", i), lat, vecs[i].expLat);
            check($sformatf("vec%0d.A", i), dutA, vecs[i].expA);
            check($sformatf("vec%0d.B", i), dutB, vecs[i].expB);
            check($sformatf("vec%0d.Y", i), dutY, vecs[i].expY);
            check($sformatf("vec%0d.zero", i), zero, vecs[i].expZero);
            check($sformatf("vec%0d.count", i), opCount, vecs[i].expCnt);
            check($sformatf("vec%0d.done_clr", i), done, 1'b0);
            check($sformatf("vec%0d.busy_clr", i), busy, 1'b0);
            modelApply(vecs[i].op, vecs[i].sw);
        end

        // Overlap: SWP running, SUB queued, XOR dropped
        dones = 0; busyDrops = 0; seenFirst = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clock);
            if (n == 1 || n == 3 || n == 5) go = 1'b0;
            if (n == 0) begin op = 4'd14; go = 1'b1; end
            if (n == 2) begin op = 4'd1;  go = 1'b1; end
            if (n == 4) begin op = 4'd7;  go = 1'b1; end
            if (done) dones++;
            if (n >= 1 && dones < 2 && !busy) busyDrops++;
        end
        check("ovl.dones", dones, 2);
        check("ovl.busy_gap", busyDrops, 0);
        check("ovl.ovf", ovfErr, 1'b1);
        modelApply(4'd14, 8'h00);
        modelApply(4'd1, 8'h00);
        checkModel("ovl");

        // Randomized serialized ops against the model
        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 15));
            rsw = 8'($urandom);
            doOp(rop, rsw, lat);
            modelApply(rop, rsw);
            check($sformatf("rnd%0d.lat", i), lat, (rop == 4'd14) ? 5 : 3);
            checkModel($sformatf("rnd%0d", i));
        end

        // Reset abort during SWP3 (A already overwritten)
        doOp(4'd15, 8'h9C, lat);
        modelApply(4'd15, 8'h9C);
        @(negedge clock);
        op = 4'd14; go = 1'b1;
        @(negedge clock);
        go = 1'b0;
        repeat (3) @(negedge clock);
        check("abort.A_swapped", dutA, mB);
        #2 reset = 1'b0;
        #1;
        check("abort.A", dutA, 8'h00);
        check("abort.B", dutB, 8'h00);
        check("abort.Y", dutY, 8'h00);
        check("abort.busy", busy, 1'b0);
        check("abort.done", done, 1'b0);
        check("abort.zero", zero, 1'b1);
        check("abort.ovf", ovfErr, 1'b0);
        check("abort.count", opCount, 8'd0);
        modelReset();
        @(negedge clock);
        reset = 1'b1;
        dones = 0;
        repeat (8) begin
            @(negedge clock);
            if (done) dones++;
        end
        check("abort.no_done", dones, 0);
        check("abort.idle_busy", busy, 1'b0);

        // Held-high go gives exactly one request
        dones = 0;
        @(negedge clock);
        op = 4'd15; swVal = 8'h11; go = 1'b1;
        for (int n = 0; n < 30; n++) begin
            @(negedge clock);
            if (n == 19) go = 1'b0;
            if (done) dones++;
        end
        modelApply(4'd15, 8'h11);
        check("held.dones", dones, 1);
        checkModel("held");

        // Counter wrap after 256 ops from reset
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        modelReset();
        for (int i = 0; i < 256; i++) begin
            doOp(4'd15, 8'(i), lat);
            modelApply(4'd15, 8'(i));
            if (i == 254) check("wrap.255", opCount, 8'd255);
        end
        check("wrap.count", opCount, 8'd0);
        checkModel("wrap");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
